radix2_dit_ibfly: RTL

//  Pipelined radix-2 decimation-in-time butterfly: the inverse-direction partner of the DIF forward butterfly.

---
 rtl/radix2_dit_ibfly_pkg.sv | 27 ++
 rtl/radix2_dit_ibfly_cmul_conj.sv | 71 +++++++
 rtl/radix2_dit_ibfly.sv | 134 +++++++++++++
 3 files changed

// File: rtl/radix2_dit_ibfly_pkg.sv
// Shared definitions for the radix-2 butterflies: twiddle Q-format, saturation helper
// and the common pipeline advance rule.
package radix2_dit_ibfly_pkg;

  // Twiddles are Q2.(TW_WIDTH-2); 1.0 = 2**(TW_WIDTH-2).
  function automatic int unsigned tw_frac(input int unsigned tw_width);
    return tw_width - 2;
  endfunction

  // Clamp a wide signed value to the signed range of a w-bit word.
  function automatic logic signed [63:0] sat_clip(input logic signed [63:0] x,
                                                  input int unsigned     w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  // All stages shift together whenever the output slot is free or being drained.
  function automatic logic stage_en(input logic out_valid, input logic out_ready);
    return !out_valid || out_ready;
  endfunction

endpackage

// File: rtl/radix2_dit_ibfly_cmul_conj.sv
// Stage 1 of the DIT butterfly: registered complex multiply b*W or b*conj(W), with a passthrough.
module radix2_dit_ibfly_cmul_conj #(
  parameter int unsigned BIT_WIDTH = 16,
  parameter int unsigned TW_WIDTH  = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               en,
  input  logic                               in_valid,
  input  logic                               inverse,
  input  logic signed [TW_WIDTH-1:0]         cos_data,
  input  logic signed [TW_WIDTH-1:0]         sin_data,
  input  logic signed [BIT_WIDTH-1:0]        re_a,
  input  logic signed [BIT_WIDTH-1:0]        im_a,
  input  logic signed [BIT_WIDTH-1:0]        re_b,
  input  logic signed [BIT_WIDTH-1:0]        im_b,
  output logic                               valid_q,
  output logic signed [BIT_WIDTH-1:0]        re_a_q,
  output logic signed [BIT_WIDTH-1:0]        im_a_q,
  output logic signed [BIT_WIDTH+TW_WIDTH:0] pr_q,
  output logic signed [BIT_WIDTH+TW_WIDTH:0] pi_q
);

  localparam int unsigned PW = BIT_WIDTH + TW_WIDTH + 1;

  logic signed [PW-1:0] br, bi, c, s, rr, ii, ri, ir;
  logic signed [PW-1:0] pr_d, pi_d;
  logic signed [BIT_WIDTH-1:0] re_a_d, im_a_d;
  logic valid_d;

  // Conjugation only flips the sign of the sin cross terms.
  always_comb begin
    br = PW'(re_b);
    bi = PW'(im_b);
    c  = PW'(cos_data);
    s  = PW'(sin_data);
    rr = br * c;
    ii = bi * s;
    ri = br * s;
    ir = bi * c;
    valid_d = valid_q;
    re_a_d  = re_a_q;
    im_a_d  = im_a_q;
    pr_d    = pr_q;
    pi_d    = pi_q;
    if (en) begin
      valid_d = in_valid;
      re_a_d  = re_a;
      im_a_d  = im_a;
      pr_d    = inverse ? (rr + ii) : (rr - ii);
      pi_d    = inverse ? (ir - ri) : (ir + ri);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      re_a_q  <= '0;
      im_a_q  <= '0;
      pr_q    <= '0;
      pi_q    <= '0;
    end else begin
      valid_q <= valid_d;
      re_a_q  <= re_a_d;
      im_a_q  <= im_a_d;
      pr_q    <= pr_d;
      pi_q    <= pi_d;
    end
  end

endmodule

// File: rtl/radix2_dit_ibfly.sv
// Two-stage radix-2 DIT butterfly for the IFFT/DIT datapath: twiddle multiply, then
// add/sub with floor scaling, saturation and a sticky overflow flag.
module radix2_dit_ibfly
  import radix2_dit_ibfly_pkg::*;
#(
  parameter int unsigned BIT_WIDTH   = 16,
  parameter int unsigned TW_WIDTH    = 16,
  parameter int unsigned SCALE_SHIFT = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_valid,
  output logic                        i_ready,
  input  logic                        i_inverse,
  input  logic signed [TW_WIDTH-1:0]  cos_data,
  input  logic signed [TW_WIDTH-1:0]  sin_data,
  input  logic signed [BIT_WIDTH-1:0] re_a,
  input  logic signed [BIT_WIDTH-1:0] im_a,
  input  logic signed [BIT_WIDTH-1:0] re_b,
  input  logic signed [BIT_WIDTH-1:0] im_b,
  output logic                        o_valid,
  input  logic                        o_ready,
  output logic signed [BIT_WIDTH-1:0] re_o1,
  output logic signed [BIT_WIDTH-1:0] im_o1,
  output logic signed [BIT_WIDTH-1:0] re_o2,
  output logic signed [BIT_WIDTH-1:0] im_o2,
  input  logic                        ovf_clr,
  output logic                        ovf_flag
);

  localparam int unsigned PW      = BIT_WIDTH + TW_WIDTH + 1;
  localparam int unsigned SW      = BIT_WIDTH + 2;
  localparam int unsigned TW_FRAC = tw_frac(TW_WIDTH);

  logic                        en;
  logic                        v1_q;
  logic signed [BIT_WIDTH-1:0] re_a_q, im_a_q;
  logic signed [PW-1:0]        pr_q, pi_q;
  logic signed [SW-1:0]        t_re, t_im;
  logic signed [SW-1:0]        pre  [4];
  logic signed [63:0]          clip [4];
  logic signed [BIT_WIDTH-1:0] res  [4];
  logic                        sat_any;

  logic                        o_valid_q, o_valid_d;
  logic signed [BIT_WIDTH-1:0] re_o1_q, re_o1_d, im_o1_q, im_o1_d;
  logic signed [BIT_WIDTH-1:0] re_o2_q, re_o2_d, im_o2_q, im_o2_d;
  logic                        ovf_flag_q, ovf_flag_d;

  assign en       = stage_en(o_valid_q, o_ready);
  assign i_ready  = en;
  assign o_valid  = o_valid_q;
  assign re_o1    = re_o1_q;
  assign im_o1    = im_o1_q;
  assign re_o2    = re_o2_q;
  assign im_o2    = im_o2_q;
  assign ovf_flag = ovf_flag_q;

  radix2_dit_ibfly_cmul_conj #(
    .BIT_WIDTH (BIT_WIDTH),
    .TW_WIDTH  (TW_WIDTH)
  ) u_cmul (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .in_valid (i_valid),
    .inverse  (i_inverse),
    .cos_data (cos_data),
    .sin_data (sin_data),
    .re_a     (re_a),
    .im_a     (im_a),
    .re_b     (re_b),
    .im_b     (im_b),
    .valid_q  (v1_q),
    .re_a_q   (re_a_q),
    .im_a_q   (im_a_q),
    .pr_q     (pr_q),
    .pi_q     (pi_q)
  );

  // Stage 2 datapath: floor back to data scale, add/sub, scale, saturate.
  always_comb begin
    t_re   = SW'(pr_q >>> TW_FRAC);
    t_im   = SW'(pi_q >>> TW_FRAC);
    pre[0] = (SW'(re_a_q) + t_re) >>> SCALE_SHIFT;
    pre[1] = (SW'(im_a_q) + t_im) >>> SCALE_SHIFT;
    pre[2] = (SW'(re_a_q) - t_re) >>> SCALE_SHIFT;
    pre[3] = (SW'(im_a_q) - t_im) >>> SCALE_SHIFT;
    sat_any = 1'b0;
    for (int k = 0; k < 4; k++) begin
      clip[k] = sat_clip(64'(pre[k]), BIT_WIDTH);
      res[k]  = BIT_WIDTH'(clip[k]);
      sat_any = sat_any | (clip[k] != 64'(pre[k]));
    end
  end

  // Output register load; an overflow set beats a simultaneous clear.
  always_comb begin
    o_valid_d  = o_valid_q;
    re_o1_d    = re_o1_q;
    im_o1_d    = im_o1_q;
    re_o2_d    = re_o2_q;
    im_o2_d    = im_o2_q;
    ovf_flag_d = ovf_flag_q;
    if (en) begin
      o_valid_d = v1_q;
      re_o1_d   = res[0];
      im_o1_d   = res[1];
      re_o2_d   = res[2];
      im_o2_d   = res[3];
    end
    if (ovf_clr) ovf_flag_d = 1'b0;
    if (en && v1_q && sat_any) ovf_flag_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid_q  <= 1'b0;
      re_o1_q    <= '0;
      im_o1_q    <= '0;
      re_o2_q    <= '0;
      im_o2_q    <= '0;
      ovf_flag_q <= 1'b0;
    end else begin
      o_valid_q  <= o_valid_d;
      re_o1_q    <= re_o1_d;
      im_o1_q    <= im_o1_d;
      re_o2_q    <= re_o2_d;
      im_o2_q    <= im_o2_d;
      ovf_flag_q <= ovf_flag_d;
    end
  end

endmodule
